// File: rtl/shift_right_seq_pkg.sv
// Shared geometry and FSM state encoding for the multi-pass lane shifter sequencer.
package shift_right_seq_pkg;

    localparam int LANES    = 10;
    localparam int LANE_W   = 5;
    localparam int WORD_W   = 50;
    localparam int MAX_STEP = 4;
    localparam int AMT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_right.sv
// Single combinational pass: shifts a 10x5-bit word right by 0..4 lanes, filling vacated lanes.
module shift_right
    import shift_right_seq_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [LANE_W-1:0] fill,
    input  logic [2:0]        shift,
    output logic [WORD_W-1:0] out,
    output logic              out_valid
);

    logic [2*WORD_W-1:0] ext;
    logic [4:0]          bit_amt;

    always_comb begin
        // Fill lanes sit above the word so a plain right shift pulls them into the top.
        ext       = {{LANES{fill}}, in};
        bit_amt   = {shift, 2'b00} + {2'b00, shift};
        out       = WORD_W'(ext >> bit_amt);
        out_valid = (shift <= 3'(MAX_STEP));
    end

endmodule

// File: rtl/shift_right_seq.sv
// Sequences up to three registered passes through one shift_right to realise a 0..15 lane shift.
module shift_right_seq
    import shift_right_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [LANE_W-1:0] in_fill,
    input  logic [AMT_W-1:0]  in_amount,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_clamped,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [LANE_W-1:0]   fill_q, fill_d;
    logic [AMT_W-1:0]    rem_q, rem_d;
    logic                clamped_q, clamped_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [2:0]          step;
    logic [WORD_W-1:0]   sh_out;
    logic                sh_valid;

    shift_right u_shift_right (
        .in        (data_q),
        .fill      (fill_q),
        .shift     (step),
        .out       (sh_out),
        .out_valid (sh_valid)
    );

    always_comb begin
        step        = (rem_q > AMT_W'(MAX_STEP)) ? 3'(MAX_STEP) : rem_q[2:0];
        state_d     = state_q;
        data_d      = data_q;
        fill_d      = fill_q;
        rem_d       = rem_q;
        clamped_d   = clamped_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d    = in_data;
                    fill_d    = in_fill;
                    clamped_d = (in_amount > AMT_W'(LANES));
                    rem_d     = (in_amount > AMT_W'(LANES)) ? AMT_W'(LANES) : in_amount;
                    state_d   = (rem_d != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d = sh_out;
                rem_d  = rem_q - {1'b0, step};
                if (rem_q == {1'b0, step}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            fill_q      <= '0;
            rem_q       <= '0;
            clamped_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            fill_q      <= fill_d;
            rem_q       <= rem_d;
            clamped_q   <= clamped_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_data    = data_q;
    assign out_clamped = clamped_q;

    a_step_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SHIFT) |-> sh_valid);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed, table-driven bench for shift_right_seq with backpressure and mid-shift reset sequences.
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] in_data;
    logic [4:0]  in_fill;
    logic [3:0]  in_amount;
    logic        out_valid;
    logic        out_ready;
    logic [49:0] out_data;
    logic        out_clamped;
    logic        busy;

    int errors = 0;
    int checks = 0;

    localparam logic [49:0] BASE = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

    typedef struct {
        logic [3:0]  amount;
        logic [4:0]  fill;
        logic [49:0] exp_data;
        logic        exp_clamped;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    shift_right_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_fill     (in_fill),
        .in_amount   (in_amount),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_clamped (out_clamped),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, lets it be accepted, and returns cycles from accept to out_valid.
    task automatic issue(input logic [3:0] amt, input logic [4:0] fl, input logic [49:0] d,
                         output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_amount = amt;
        in_fill   = fl;
        in_data   = d;
        tick();
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        vecs[0] = '{4'd0,  5'h1F, BASE, 1'b0, 0};
        vecs[1] = '{4'd3,  5'h1F, {5'h1F, 5'h1F, 5'h1F, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3}, 1'b0, 1};
        vecs[2] = '{4'd7,  5'h1F, {{7{5'h1F}}, 5'd9, 5'd8, 5'd7}, 1'b0, 2};
        vecs[3] = '{4'd13, 5'h1F, {10{5'h1F}}, 1'b1, 3};
        vecs[4] = '{4'd10, 5'h1F, {10{5'h1F}}, 1'b0, 3};
        vecs[5] = '{4'd4,  5'h0A, {{4{5'h0A}}, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4}, 1'b0, 1};
        vecs[6] = '{4'd9,  5'h15, {{9{5'h15}}, 5'd9}, 1'b0, 3};
        vecs[7] = '{4'd1,  5'h00, {5'h00, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b0, 1};
        vecs[8] = '{4'd15, 5'h03, {10{5'h03}}, 1'b1, 3};
        vecs[9] = '{4'd5,  5'h1F, {{5{5'h1F}}, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_fill   = '0;
        in_amount = '0;
        out_ready = 1'b1;
        #12;
        chk("reset_in_ready",    64'(in_ready),    64'd1);
        chk("reset_out_valid",   64'(out_valid),   64'd0);
        chk("reset_busy",        64'(busy),        64'd0);
        chk("reset_out_data",    64'(out_data),    64'd0);
        chk("reset_out_clamped", 64'(out_clamped), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].amount, vecs[i].fill, BASE, lat);
            chk($sformatf("vec%0d_latency", i),  64'(lat),         64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_data", i),     64'(out_data),    64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_clamped", i),  64'(out_clamped), 64'(vecs[i].exp_clamped));
            chk($sformatf("vec%0d_busy_done", i), 64'(busy),       64'd1);
            tick();
            chk($sformatf("vec%0d_idle_ready", i), 64'(in_ready),  64'd1);
            chk($sformatf("vec%0d_valid_drop", i), 64'(out_valid), 64'd0);
        end

        // Backpressure: result must hold and new requests must be ignored while DONE.
        out_ready = 1'b0;
        issue(4'd5, 5'h1F, BASE, lat);
        chk("bp_latency", 64'(lat), 64'd2);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                in_valid  = 1'b1;
                in_amount = 4'd0;
                in_fill   = 5'h00;
                in_data   = {50{1'b1}};
            end
            chk($sformatf("bp_valid_c%0d", c),    64'(out_valid),   64'd1);
            chk($sformatf("bp_data_c%0d", c),     64'(out_data),    64'({{5{5'h1F}}, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5}));
            chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready),    64'd0);
            chk($sformatf("bp_clamped_c%0d", c),  64'(out_clamped), 64'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 64'(in_ready),  64'd1);
        chk("bp_release_valid",    64'(out_valid), 64'd0);
        tick();
        chk("bp_ignored_req_busy",  64'(busy),      64'd0);
        chk("bp_ignored_req_valid", 64'(out_valid), 64'd0);

        // Reset pulsed during SHIFT of a 9-lane request abandons it.
        in_valid  = 1'b1;
        in_amount = 4'd9;
        in_fill   = 5'h1F;
        in_data   = BASE;
        tick();
        in_valid  = 1'b0;
        tick();
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready",    64'(in_ready),    64'd1);
        chk("rst_mid_out_valid",   64'(out_valid),   64'd0);
        chk("rst_mid_busy",        64'(busy),        64'd0);
        chk("rst_mid_out_data",    64'(out_data),    64'd0);
        chk("rst_mid_out_clamped", 64'(out_clamped), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst_no_output_c%0d", c), 64'(out_valid), 64'd0);
            tick();
        end
        issue(4'd4, 5'h1F, BASE, lat);
        chk("post_rst_latency", 64'(lat),         64'd1);
        chk("post_rst_data",    64'(out_data),    64'({{4{5'h1F}}, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4}));
        chk("post_rst_clamped", 64'(out_clamped), 64'd0);
        tick();
        chk("post_rst_idle", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
